stack_rev_ctrl: RTL and testbench

- Initiator for the 8x8 LIFO stack command interface. It drives cmd/data_in and consumes data_out/full/empty/error.
- Accepts a byte stream in frames and pushes each chunk of up to DEPTH bytes into the stack. It then pops the chunk back out, emitting the bytes in reversed order on a valid/ready output stream.
- Sits between an upstream byte source and the stack instance, and owns all stack command sequencing.

---
 rtl/stack_rev_ctrl_pkg.sv | 13 +
 rtl/stack_rev_ctrl_out_stage.sv | 39 +++
 rtl/stack_rev_ctrl.sv | 150 +++++++++++++++
 tb/tb_stack_rev_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_rev_ctrl_pkg.sv
// stack_rev_ctrl_pkg: stack command encodings, size defaults and controller states
package stack_rev_ctrl_pkg;
  localparam int DEPTH_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int POP_LAT_DEF = 2;
  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_CLEAR = 2'b01,
    CMD_PUSH  = 2'b10,
    CMD_POP   = 2'b11
  } stk_cmd_e;
  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_FILL, ST_DRAIN, ST_FAULT} state_e;
endpackage

// File: rtl/stack_rev_ctrl_out_stage.sv
// stack_rev_ctrl_out_stage: one-entry registered output holding data/last under valid/ready
module stack_rev_ctrl_out_stage
  import stack_rev_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          load,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last
);
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;
  always_comb begin
    valid_d = flush ? 1'b0 : load ? 1'b1 : (valid_q && out_ready) ? 1'b0 : valid_q;
    data_d  = load ? ld_data : data_q;
    last_d  = flush ? 1'b0 : load ? ld_last : last_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
endmodule

// File: rtl/stack_rev_ctrl.sv
// stack_rev_ctrl: reverses byte frames in chunks of up to DEPTH bytes through an external LIFO stack
module stack_rev_ctrl
  import stack_rev_ctrl_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int DW      = DW_DEF,
  parameter int POP_LAT = POP_LAT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [1:0]    stk_cmd,
  output logic [DW-1:0] stk_data_in,
  input  logic [DW-1:0] stk_data_out,
  input  logic          stk_full,
  input  logic          stk_empty,
  input  logic          stk_error,
  output logic          fault,
  output logic          busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(POP_LAT + 4);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_dly_q, cnt_inc;
  logic [WW-1:0] w_q, w_d;
  logic          last_pend_q, last_pend_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [DW-1:0] din_q, din_d;
  logic          in_ready_q, in_ready_d, fault_q, fault_d, busy_q, busy_d;
  logic          hs_in, hs_out, chk, bad, go_fault, hold, load, flush;
  always_comb begin
    hs_in       = in_valid && in_ready_q;
    hs_out      = out_valid && out_ready;
    cnt_inc     = cnt_q + 1'b1;
    chk         = state_q == ST_IDLE || state_q == ST_FILL || state_q == ST_DRAIN;
    bad         = stk_error || (stk_full && cnt_dly_q < CW'(DEPTH)) || (stk_empty && cnt_dly_q != '0);
    go_fault    = (chk && bad) || (state_q == ST_INIT && w_q == WW'(2) && !stk_empty);
    state_d     = state_q;
    cnt_d       = cnt_q;
    w_d         = w_q;
    last_pend_d = last_pend_q;
    cmd_d       = CMD_NOP;
    din_d       = din_q;
    fault_d     = fault_q;
    hold        = 1'b0;
    load        = 1'b0;
    flush       = 1'b0;
    case (state_q)
      ST_INIT: begin
        w_d   = w_q + 1'b1;
        cmd_d = w_q == '0 ? CMD_CLEAR : CMD_NOP;
        if (w_q == WW'(3)) begin
          state_d = ST_IDLE;
          w_d     = '0;
        end
      end
      ST_IDLE, ST_FILL: if (hs_in) begin
        cmd_d       = CMD_PUSH;
        din_d       = in_data;
        cnt_d       = cnt_inc;
        last_pend_d = last_pend_q || in_last;
        state_d     = (in_last || cnt_inc == CW'(DEPTH)) ? ST_DRAIN : ST_FILL;
        w_d         = '0;
      end
      ST_DRAIN: begin
        hold = w_q == WW'(POP_LAT + 1);
        if (w_q == '0 || (hold && hs_out && cnt_q != '0)) begin
          cmd_d = CMD_POP;
          cnt_d = cnt_q - 1'b1;
          w_d   = WW'(1);
        end else if (hold) begin
          if (hs_out) begin
            state_d     = last_pend_q ? ST_IDLE : ST_FILL;
            last_pend_d = 1'b0;
            w_d         = '0;
          end
        end else begin
          w_d  = w_q + 1'b1;
          load = w_q == WW'(POP_LAT);
        end
      end
      ST_FAULT: begin
        state_d = ST_INIT;
        w_d     = WW'(2);
      end
      default: state_d = ST_INIT;
    endcase
    // The CLEAR issued on fault entry stands in for INIT's own clear, so INIT resumes at its settle wait.
    if (go_fault) begin
      state_d     = ST_FAULT;
      cmd_d       = CMD_CLEAR;
      fault_d     = 1'b1;
      flush       = 1'b1;
      load        = 1'b0;
      cnt_d       = '0;
      last_pend_d = 1'b0;
      w_d         = '0;
    end
    in_ready_d = state_d == ST_IDLE || (state_d == ST_FILL && cnt_d < CW'(DEPTH));
    busy_d     = state_d != ST_IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      cnt_dly_q   <= '0;
      w_q         <= '0;
      last_pend_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      din_q       <= '0;
      in_ready_q  <= 1'b0;
      fault_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cnt_dly_q   <= cnt_q;
      w_q         <= w_d;
      last_pend_q <= last_pend_d;
      cmd_q       <= cmd_d;
      din_q       <= din_d;
      in_ready_q  <= in_ready_d;
      fault_q     <= fault_d;
      busy_q      <= busy_d;
    end
  stack_rev_ctrl_out_stage #(.DW(DW)) u_out (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .load      (load),
    .ld_data   (stk_data_out),
    .ld_last   (last_pend_q && cnt_q == '0),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );
  assign stk_cmd     = cmd_q;
  assign stk_data_in = din_q;
  assign in_ready    = in_ready_q;
  assign fault       = fault_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_stack_rev_ctrl.sv
// tb_stack_rev_ctrl: directed bench for stack_rev_ctrl driving a behavioural 8x8 LIFO stack
module tb_stack_rev_ctrl;
  logic       clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid, out_last, fault, busy;
  logic [7:0] out_data, stk_data_in;
  logic [1:0] stk_cmd;
  logic [7:0] mem [8];
  logic [3:0] sp = '0;
  logic       full_r = 1'b0, empty_r = 1'b1, err_r = 1'b0, inj = 1'b0;
  logic [7:0] dout_r = '0;
  int         pc = 0, inj_at = 0, mode = 0, cyc = 0;
  int         n_chk = 0, n_fail = 0;
  int         n_clr = 0, n_push = 0, n_pop = 0, n_ov = 0, n_rv = 0, n_stab = 0, n_stall = 0, since_pop = 99;
  logic       pv = 1'b0;
  logic [8:0] pd = '0;
  logic [8:0] got [$];
  logic [8:0] ex [$];
  logic [7:0] fb [$];
  int         gb = 0;
  always #5 clk = ~clk;
  stack_rev_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .stk_cmd(stk_cmd), .stk_data_in(stk_data_in), .stk_data_out(dout_r),
    .stk_full(full_r), .stk_empty(empty_r), .stk_error(err_r), .fault(fault), .busy(busy)
  );
  always @(posedge clk)
    if (stk_cmd == 2'b01) begin
      sp <= '0;
      err_r <= 1'b0;
    end else if (stk_cmd == 2'b10) begin
      if (sp == 4'd8) err_r <= 1'b1;
      else begin
        mem[sp[2:0]] <= stk_data_in;
        sp <= sp + 4'd1;
      end
      pc <= pc + 1;
      if (inj && pc == inj_at) err_r <= 1'b1;
    end else if (stk_cmd == 2'b11) begin
      if (sp == 4'd0) err_r <= 1'b1;
      else begin
        dout_r <= mem[3'(sp - 4'd1)];
        sp <= sp - 4'd1;
      end
    end
  always @(negedge clk) begin
    full_r <= sp == 4'd8;
    empty_r <= sp == 4'd0;
  end
  always @(negedge clk) begin
    if (stk_cmd == 2'b01) n_clr++;
    if (stk_cmd == 2'b10) n_push++;
    since_pop = stk_cmd == 2'b11 ? 0 : since_pop + 1;
    if (stk_cmd == 2'b11) n_pop++;
    if (out_valid) n_ov++;
    if (in_ready && (out_valid || since_pop <= 2)) n_rv++;
    if (pv && !(out_valid && {out_last, out_data} == pd)) n_stab++;
    if (out_valid && !out_ready) n_stall++;
    pv = out_valid && !out_ready;
    pd = {out_last, out_data};
    if (out_valid && out_ready) got.push_back({out_last, out_data});
  end
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0) : 1'b0;
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    logic hs;
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    do begin
      hs = in_ready;
      tick();
      t++;
    end while (!hs && t < 200);
    in_valid = 1'b0;
    in_last = 1'b0;
    check("in_handshake", {31'd0, hs}, 1);
  endtask
  task automatic send_frame(input logic with_last);
    foreach (fb[i]) send(fb[i], with_last && i == fb.size() - 1);
  endtask
  task automatic expect_out();
    int t;
    t = 0;
    while (got.size() < gb + ex.size() && t < 500) begin
      tick();
      t++;
    end
    check("out_count", got.size() - gb, ex.size());
    foreach (ex[i]) check($sformatf("out[%0d]", i), gb + i < got.size() ? {23'd0, got[gb + i]} : 32'hx, {23'd0, ex[i]});
  endtask
  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 30) begin
      tick();
      t++;
    end
    check("idle_reached", {31'd0, busy}, 0);
  endtask
  initial begin
    int c0, p0, q0, o0, r0, s0, st0, c_at, b_at, t;
    out_ready = 1'b1;
    reset = 1'b1;
    tick(3);
    check("rst_cmd", stk_cmd, 0);
    check("rst_din", stk_data_in, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_fault", fault, 0);
    check("rst_busy", busy, 1);
    c0 = n_clr;
    c_at = -1;
    b_at = -1;
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (stk_cmd == 2'b01 && c_at < 0) c_at = i;
      if (!busy && b_at < 0) b_at = i;
    end
    check("init_clear_count", n_clr - c0, 1);
    check("init_busy_delay", b_at - c_at, 3);
    check("init_fault", fault, 0);
    check("init_in_ready", in_ready, 1);
    mode = 0;
    p0 = n_push;
    q0 = n_pop;
    gb = got.size();
    fb.delete();
    fb.push_back(8'h11);
    fb.push_back(8'h22);
    fb.push_back(8'h33);
    ex.delete();
    ex.push_back(9'h033);
    ex.push_back(9'h022);
    ex.push_back(9'h111);
    send_frame(1'b1);
    expect_out();
    tick(3);
    check("f3_push", n_push - p0, 3);
    check("f3_pop", n_pop - q0, 3);
    check("f3_busy", busy, 0);
    check("f3_in_ready", in_ready, 1);
    p0 = n_push;
    q0 = n_pop;
    r0 = n_rv;
    gb = got.size();
    fb.delete();
    for (int i = 0; i < 11; i++) fb.push_back(8'(i));
    ex.delete();
    for (int i = 7; i >= 0; i--) ex.push_back({1'b0, 8'(i)});
    ex.push_back(9'h00A);
    ex.push_back(9'h009);
    ex.push_back(9'h108);
    send_frame(1'b1);
    expect_out();
    tick(3);
    check("f11_push", n_push - p0, 11);
    check("f11_pop", n_pop - q0, 11);
    check("f11_in_ready_in_drain", n_rv - r0, 0);
    check("f11_fault", fault, 0);
    mode = 1;
    s0 = n_stab;
    st0 = n_stall;
    gb = got.size();
    fb.delete();
    fb.push_back(8'h11);
    fb.push_back(8'h22);
    fb.push_back(8'h33);
    ex.delete();
    ex.push_back(9'h033);
    ex.push_back(9'h022);
    ex.push_back(9'h111);
    send_frame(1'b1);
    expect_out();
    tick(3);
    check("bp_stable", n_stab - s0, 0);
    check("bp_stalled", {31'd0, n_stall - st0 > 0}, 1);
    mode = 0;
    tick(2);
    c0 = n_clr;
    o0 = n_ov;
    inj_at = pc + 1;
    inj = 1'b1;
    send(8'h5A, 1'b0);
    send(8'h5B, 1'b0);
    t = 0;
    while (!fault && t < 20) begin
      tick();
      t++;
    end
    check("err_fault", fault, 1);
    wait_idle();
    inj = 1'b0;
    check("err_clear_count", n_clr - c0, 1);
    check("err_out_valid", n_ov - o0, 0);
    check("err_in_ready", in_ready, 1);
    reset = 1'b1;
    tick(2);
    check("rst2_fault", fault, 0);
    reset = 1'b0;
    wait_idle();
    mode = 2;
    fb.delete();
    for (int i = 1; i <= 5; i++) fb.push_back(8'(i));
    send_frame(1'b1);
    t = 0;
    while (!out_valid && t < 20) begin
      tick();
      t++;
    end
    check("mid_valid", out_valid, 1);
    check("mid_data", out_data, 8'h05);
    reset = 1'b1;
    #1;
    check("async_cmd", stk_cmd, 0);
    check("async_out_valid", out_valid, 0);
    check("async_out_data", out_data, 0);
    check("async_in_ready", in_ready, 0);
    check("async_busy", busy, 1);
    tick(2);
    mode = 0;
    c0 = n_clr;
    reset = 1'b0;
    wait_idle();
    check("reinit_clear_count", n_clr - c0, 1);
    gb = got.size();
    fb.delete();
    fb.push_back(8'hAA);
    fb.push_back(8'hBB);
    fb.push_back(8'hCC);
    fb.push_back(8'hDD);
    ex.delete();
    ex.push_back(9'h0DD);
    ex.push_back(9'h0CC);
    ex.push_back(9'h0BB);
    ex.push_back(9'h1AA);
    send_frame(1'b1);
    expect_out();
    tick(2);
    check("post_rst_fault", fault, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
